// File: rtl/core_pkg.sv
// Shared types and constants for the branch/PC stage of the single-cycle core.
package core_pkg;

  // Branch condition codes carried in funct3.
  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_NO2  = 3'b010,
    BR_NO3  = 3'b011,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_cond_e;

  // PC sequencing states.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } pc_state_e;

  // Default reset and trap vectors.
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/br_cond.sv
// Purely combinational branch-condition decode from funct3 and comparator flags.
module br_cond
  import core_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_eq,
  input  logic       i_lt,
  output logic       o_cond
);

  // Select the comparator flag (or its inverse) named by funct3.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    o_cond = 1'b0;
    case (br_cond_e'(i_funct3))
      BR_BEQ:            o_cond = i_eq;
      BR_BNE:            o_cond = !i_eq;
      BR_BLT,  BR_BLTU:  o_cond = i_lt;
      BR_BGE,  BR_BGEU:  o_cond = !i_lt;
      default:           o_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Branch resolution, next-PC selection, PC register, misaligned-target trap
// and retired-instruction counter.
module branch_pc_unit #(
  parameter int          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = core_pkg::RESET_VEC,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = core_pkg::TRAP_VEC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_en,
  input  logic              is_branch,
  input  logic              is_jal,
  input  logic              is_jalr,
  input  logic [2:0]        funct3,
  input  logic              br_equal,
  input  logic              br_less,
  input  logic [ADDR_W-1:0] rs1_data,
  input  logic [ADDR_W-1:0] imm,
  output logic              br_unsigned,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_four,
  output logic              pc_valid,
  output logic              br_taken,
  output logic              trap,
  output logic [ADDR_W-1:0] bad_addr,
  output logic [31:0]       retired
);

  import core_pkg::pc_state_e;
  import core_pkg::BOOT;
  import core_pkg::RUN;
  import core_pkg::TRAP;

  pc_state_e         r_state;
  pc_state_e         w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_bad_addr;
  logic [31:0]       r_retired;

  logic              w_cond;
  logic              w_xfer;
  logic              w_taken;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_misaligned;
  logic              w_advance;

  br_cond u_br_cond (
    .i_funct3 (funct3),
    .i_eq     (br_equal),
    .i_lt     (br_less),
    .o_cond   (w_cond)
  );

  // Target: JALR base+imm with bit 0 cleared wins over the PC-relative forms.
  always_comb begin
    w_target = r_pc + imm;
    if (is_jalr) begin
      w_target = (rs1_data + imm) & ~{{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  assign w_xfer       = is_jalr | is_jal | (is_branch & w_cond);
  assign w_taken      = (r_state == RUN) & w_xfer;
  assign w_misaligned = w_taken & (w_target[1:0] != 2'b00);
  assign pc_four      = r_pc + ADDR_W'(4);
  assign w_next_pc    = w_taken ? w_target : pc_four;
  assign w_advance    = (r_state == RUN) & pc_en;

  // Next-state decode: BOOT and TRAP last one cycle; RUN traps on an enabled misaligned transfer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      BOOT:    w_next_state = RUN;
      RUN:     if (pc_en && w_misaligned) w_next_state = TRAP;
      TRAP:    w_next_state = RUN;
      default: w_next_state = BOOT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_next_state;
  end

  // PC, trap address and retire counter advance only on an enabled RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_VEC;
      r_bad_addr <= '0;
      r_retired  <= '0;
    end else if (w_advance) begin
      if (w_misaligned) begin
        r_pc       <= TRAP_VEC;
        r_bad_addr <= w_target;
      end else begin
        r_pc      <= w_next_pc;
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  assign br_unsigned = funct3[1];
  assign br_taken    = w_taken;
  assign pc          = r_pc;
  assign pc_valid    = (r_state == RUN);
  assign trap        = (r_state == TRAP);
  assign bad_addr    = r_bad_addr;
  assign retired     = r_retired;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed-vector bench for branch_pc_unit with hand-computed expectations.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_en;
  logic        is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic        br_equal, br_less;
  logic [31:0] rs1_data, imm;
  logic        br_unsigned;
  logic [31:0] pc, pc_four;
  logic        pc_valid, br_taken, trap;
  logic [31:0] bad_addr, retired;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  branch_pc_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_en       (pc_en),
    .is_branch   (is_branch),
    .is_jal      (is_jal),
    .is_jalr     (is_jalr),
    .funct3      (funct3),
    .br_equal    (br_equal),
    .br_less     (br_less),
    .rs1_data    (rs1_data),
    .imm         (imm),
    .br_unsigned (br_unsigned),
    .pc          (pc),
    .pc_four     (pc_four),
    .pc_valid    (pc_valid),
    .br_taken    (br_taken),
    .trap        (trap),
    .bad_addr    (bad_addr),
    .retired     (retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    funct3 = 3'b000; br_equal = 1'b0; br_less = 1'b0;
    rs1_data = '0; imm = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    pc_en = 1'b1;
    idle();
    #12;
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'b0, pc_valid}, 32'd0);
    check("rst_retired", retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("boot_pc", pc, 32'h0);
    check("boot_valid", {31'b0, pc_valid}, 32'd0);

    // Sequential fetch after boot.
    step(); check("run0_pc", pc, 32'h0); check("run0_valid", {31'b0, pc_valid}, 32'd1);
    check("run0_pc_four", pc_four, 32'h4);
    step(); check("seq_pc4", pc, 32'h4);
    step(); check("seq_pc8", pc, 32'h8); check("seq_retired2", retired, 32'd2);

    // BEQ at 0x8, imm 0x10.
    is_branch = 1'b1; funct3 = 3'b000; imm = 32'h10; br_equal = 1'b0; #1;
    check("beq_ne_taken", {31'b0, br_taken}, 32'd0);
    br_equal = 1'b1; #1;
    check("beq_eq_taken", {31'b0, br_taken}, 32'd1);
    step(); check("beq_eq_pc", pc, 32'h18); check("beq_retired", retired, 32'd3);
    br_equal = 1'b0;
    step(); check("beq_ne_pc", pc, 32'h1C);
    idle();
    step(); check("to_0x20", pc, 32'h20); check("retired5", retired, 32'd5);

    // BLTU with negative imm wraps back to 0x18.
    is_branch = 1'b1; funct3 = 3'b110; imm = 32'hFFFF_FFF8; br_less = 1'b1; #1;
    check("bltu_unsigned", {31'b0, br_unsigned}, 32'd1);
    check("bltu_taken", {31'b0, br_taken}, 32'd1);
    step(); check("bltu_pc", pc, 32'h18);

    // BGE with lt=1 and reserved code 010 are not taken.
    funct3 = 3'b101; br_less = 1'b1; #1;
    check("bge_lt_taken", {31'b0, br_taken}, 32'd0);
    check("bge_signed", {31'b0, br_unsigned}, 32'd0);
    funct3 = 3'b010; br_equal = 1'b1; #1;
    check("f010_taken", {31'b0, br_taken}, 32'd0);
    funct3 = 3'b001; br_equal = 1'b0; #1;
    check("bne_taken", {31'b0, br_taken}, 32'd1);
    idle();

    // Misaligned JALR traps.
    is_jalr = 1'b1; rs1_data = 32'h1003; imm = 32'h0; #1;
    check("jalr_taken", {31'b0, br_taken}, 32'd1);
    step();
    check("trap_pc", pc, 32'h100);
    check("trap_pulse", {31'b0, trap}, 32'd1);
    check("trap_valid", {31'b0, pc_valid}, 32'd0);
    check("trap_bad_addr", bad_addr, 32'h1002);
    check("trap_retired", retired, 32'd6);
    check("trap_no_taken", {31'b0, br_taken}, 32'd0);
    idle();
    step();
    check("post_trap_pc", pc, 32'h100);
    check("post_trap_trap", {31'b0, trap}, 32'd0);
    check("post_trap_valid", {31'b0, pc_valid}, 32'd1);
    check("post_trap_retired", retired, 32'd6);

    // Taken JAL stalled for three edges, then redirected once.
    is_jal = 1'b1; imm = 32'h40; pc_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check("stall_pc", pc, 32'h100);
    end
    check("stall_retired", retired, 32'd6);
    pc_en = 1'b1;
    step(); check("jal_pc", pc, 32'h140); check("jal_retired", retired, 32'd7);

    // JAL and JALR together: JALR target wins.
    is_jalr = 1'b1; rs1_data = 32'h200; imm = 32'h10;
    step(); check("jal_jalr_pc", pc, 32'h210);
    idle();

    // Stalled misaligned transfer holds everything.
    is_jalr = 1'b1; rs1_data = 32'h1003; pc_en = 1'b0;
    step();
    check("stall_mis_pc", pc, 32'h210);
    check("stall_mis_trap", {31'b0, trap}, 32'd0);
    check("stall_mis_bad", bad_addr, 32'h1002);
    idle(); pc_en = 1'b1;

    // Retire counter wrap.
    @(negedge clk);
    dut.r_retired = 32'hFFFF_FFFF;
    #1;
    check("preload_retired", retired, 32'hFFFF_FFFF);
    step(); check("wrap_retired", retired, 32'd0); check("wrap_pc", pc, 32'h214);

    // Asynchronous reset between edges.
    is_jal = 1'b1; imm = 32'h8;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pc", pc, 32'h0);
    check("async_valid", {31'b0, pc_valid}, 32'd0);
    check("async_taken", {31'b0, br_taken}, 32'd0);
    check("async_trap", {31'b0, trap}, 32'd0);
    check("async_bad", bad_addr, 32'h0);
    check("async_retired", retired, 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step(); check("reboot_valid", {31'b0, pc_valid}, 32'd1); check("reboot_pc", pc, 32'h0);
    step(); check("reboot_pc4", pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Branch-resolution and program-counter stage of the single-cycle core. It sits directly downstream of the operand comparator: it consumes the comparator's `equal`/`less` results, decodes the branch condition, and computes the next PC. It holds the PC register, detects misaligned control-transfer targets, and counts retired instructions. It also drives the signed/unsigned select back to the compare path, which applies the MSB flip.

## Interface
- `ADDR_W`, 32: PC and address width.
- `RESET_VEC`, 32'h0000_0000: PC value loaded on reset.
- `TRAP_VEC`, 32'h0000_0100: PC loaded on a misaligned-target trap.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `pc_en`  in  1  advance enable; 0 = stall, PC held.
- `is_branch`  in  1  current instruction is a conditional branch.
- `is_jal`  in  1  current instruction is JAL.
- `is_jalr`  in  1  current instruction is JALR.
- `funct3`  in  3  branch condition code.
- `br_equal`  in  1  comparator result: rs1 == rs2.
- `br_less`  in  1  comparator result: rs1 < rs2, signedness per `br_unsigned`.
- `rs1_data`  in  ADDR_W  JALR base.
- `imm`  in  ADDR_W  sign-extended immediate.
- `br_unsigned`  out  1  `funct3[1]`; instructs the compare path to skip the MSB flip.
- `pc`  out  ADDR_W  current PC (registered).
- `pc_four`  out  ADDR_W  `pc + 4`, used as link value.
- `pc_valid`  out  1  `pc` holds a fetchable instruction this cycle.
- `br_taken`  out  1  control transfer taken this cycle.
- `trap`  out  1  one-cycle pulse when in the TRAP state.
- `bad_addr`  out  ADDR_W  last misaligned target, captured at the trap.
- `retired`  out  32  retired-instruction count.

## Operation
- Condition decode:
  - 000 BEQ = `eq`; 001 BNE = `!eq`.
  - 100 BLT and 110 BLTU = `lt`; 101 BGE and 111 BGEU = `!lt`.
  - 010 and 011 are never taken.
- `br_taken` = `is_jalr | is_jal | (is_branch & cond)`. It is 0 outside RUN.
- Target selection, priority `is_jalr` > `is_jal` > `is_branch`:
  - JALR target = `(rs1_data + imm) & ~1`.
  - JAL and branch target = `pc + imm`.
- All adds are modulo 2^ADDR_W; overflow wraps silently.
- `next_pc` = target if `br_taken`, else `pc_four`.
- Misaligned: `br_taken` and `target[1:0] != 0`.
- FSM states and transitions:
  - BOOT: entered on reset. `pc` = RESET_VEC, `pc_valid` = 0. Always goes to RUN on the next edge.
  - RUN: `pc_valid` = 1.
    - If `pc_en` and not misaligned: `pc <= next_pc`, `retired++`.
    - If `pc_en` and misaligned: `pc <= TRAP_VEC`, `bad_addr <= target`, go to TRAP. `retired` is not incremented.
    - If `!pc_en`: all state held, including the misaligned case.
  - TRAP: `trap` = 1, `pc_valid` = 0, `pc` holds TRAP_VEC. Ignores `pc_en` and all inputs. Goes to RUN on the next edge.
- `retired` wraps from 0xFFFF_FFFF to 0.
- Reset values: `pc` = RESET_VEC; `bad_addr` = 0; `retired` = 0; state = BOOT; `trap` = 0; `pc_valid` = 0; `br_taken` = 0.

## Timing
- `br_taken`, `pc_four`, `br_unsigned` and the target are combinational from the current inputs and `pc`. There is no pipeline.
- `pc`, `bad_addr`, `retired` and the state change only on a rising `clk` edge. Redirect latency is 1 cycle.
- Reset mid-operation: asserting `rst_n` low forces the reset values immediately, regardless of `clk`. After deassertion, the block spends exactly one cycle in BOOT, then enters RUN.
- Stall during a taken branch: the redirect is deferred. It occurs on the first edge with `pc_en` = 1 while the inputs are still presented.
- Simultaneous `is_jal` and `is_jalr`: JALR wins. `br_taken` = 1 either way.

## Structure
- Shared package `core_pkg` holds:
  - the `br_cond_e` enum for the funct3 codes;
  - the `pc_state_e` enum {BOOT, RUN, TRAP};
  - default vector constants RESET_VEC and TRAP_VEC.
- One sub-module, `br_cond`, is natural: the purely combinational decode of `funct3`/`eq`/`lt` into `cond`. The FSM, adders and registers stay in the top level.

## Test plan
- Reset release, `pc_en` = 1, no control transfer → `pc` sequence 0x0 (BOOT, valid 0), 0x0 (RUN), 0x4, 0x8; `retired` = 2 after the third edge.
- BEQ at PC 0x8 with `imm` = 0x10 → redirect depends on `eq`:
  - `eq` = 1: `br_taken` = 1 and next `pc` = 0x18.
  - `eq` = 0: next `pc` = 0xC.
- BLTU with `imm` = 0xFFFF_FFF8 at PC 0x20 → `br_unsigned` = 1; with `lt` = 1, next `pc` = 0x18 (wrap arithmetic).
- JALR with `rs1` = 0x1003 and `imm` = 0 → target 0x1002, misaligned. Required response:
  - `pc` = 0x100 and `trap` = 1 for one cycle, `bad_addr` = 0x1002;
  - `retired` unchanged, then RUN resumes at 0x100.
- Taken JAL held with `pc_en` = 0 for 3 cycles, then `pc_en` = 1 → `pc` constant for 3 cycles, then redirects once.
- Preload `retired` = 0xFFFF_FFFF via long run or force, then advance one instruction → `retired` = 0. Also assert `rst_n` low between edges → all outputs at reset values without waiting for a clock edge.
